// File: rtl/pipe_hazard_if.sv
// Pipeline <-> hazard sequencer signal bundle: hazard inputs from IF/ID/EX/MEM
// and the per-stage stall/kill/bubble/redirect controls returned to the pipeline.
interface pipe_hazard_if #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
);
    // Handshake semantics: an ibus/dbus access is pending while *_valid=1 and
    // completes in the cycle its *_data_ok=1; the pipeline must hold the
    // request stable until then. There is no ready path: stalls are the backpressure.
    logic              ireq_valid;
    logic              ireq_data_ok;
    logic              dreq_valid;
    logic              dreq_data_ok;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              ex_valid;
    logic              ex_memread;
    logic [4:0]        ex_rd;
    logic              ex_flush;
    logic [ADDR_W-1:0] ex_target;

    logic              stall_if;
    logic              stall_id;
    logic              stall_ex;
    logic              stall_mem;
    logic              kill_if;
    logic              bubble_ex;
    logic              bubble_wb;
    logic              pc_redirect;
    logic [ADDR_W-1:0] redir_pc;
    logic              fetch_drop;
    logic [CNT_W-1:0]  stall_cnt;
    logic              state_dbg;   // 1 = HOLD (redirect parked behind an in-flight fetch)

    modport master (
        output ireq_valid, ireq_data_ok, dreq_valid, dreq_data_ok,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_valid, ex_memread, ex_rd, ex_flush, ex_target,
        input  stall_if, stall_id, stall_ex, stall_mem, kill_if, bubble_ex,
               bubble_wb, pc_redirect, redir_pc, fetch_drop, stall_cnt, state_dbg
    );

    modport slave (
        input  ireq_valid, ireq_data_ok, dreq_valid, dreq_data_ok,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_valid, ex_memread, ex_rd, ex_flush, ex_target,
        output stall_if, stall_id, stall_ex, stall_mem, kill_if, bubble_ex,
               bubble_wb, pc_redirect, redir_pc, fetch_drop, stall_cnt, state_dbg
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges dbus wait,
// EX redirect, load-use and ibus wait into per-stage controls; counts IF stalls.
module pipe_hazard_ctrl #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         reset,
    pipe_hazard_if.slave hz
);
    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] held_pc, held_pc_nxt;
    logic [CNT_W-1:0]  stall_cnt;

    logic dstall, lu, istall;
    logic stall_if, stall_id, stall_ex, stall_mem;
    logic kill_if, bubble_ex, bubble_wb, pc_redirect, fetch_drop;
    logic [ADDR_W-1:0] redir_pc;

    assign dstall = hz.dreq_valid & ~hz.dreq_data_ok;
    assign istall = hz.ireq_valid & ~hz.ireq_data_ok;
    assign lu     = hz.ex_valid & hz.ex_memread & (hz.ex_rd != 5'd0) &
                    ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        state_nxt   = state;
        held_pc_nxt = held_pc;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        stall_mem   = 1'b0;
        kill_if     = 1'b0;
        bubble_ex   = 1'b0;
        bubble_wb   = 1'b0;
        pc_redirect = 1'b0;
        fetch_drop  = 1'b0;
        redir_pc    = '0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    redir_pc = hz.ex_target;
                    if (dstall) begin
                        // EX stays frozen, so any pending ex_flush is re-presented later.
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                        bubble_wb = 1'b1;
                    end else if (hz.ex_flush) begin
                        kill_if   = 1'b1;
                        bubble_ex = 1'b1;
                        if (istall) begin
                            held_pc_nxt = hz.ex_target;
                            state_nxt   = HOLD;
                        end else begin
                            pc_redirect = 1'b1;
                            fetch_drop  = hz.ireq_data_ok;
                        end
                    end else if (lu) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (istall) begin
                        stall_if = 1'b1;
                        kill_if  = 1'b1;
                    end
                end
                HOLD: begin
                    // Keep the ibus address stable until the squashed fetch returns.
                    stall_if = 1'b1;
                    kill_if  = 1'b1;
                    redir_pc = held_pc;
                    if (hz.ireq_data_ok) begin
                        fetch_drop  = 1'b1;
                        pc_redirect = 1'b1;
                        state_nxt   = RUN;
                    end
                    if (dstall) begin
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                        bubble_wb = 1'b1;
                    end
                    if (hz.ex_flush) held_pc_nxt = hz.ex_target;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            held_pc   <= '0;
            stall_cnt <= '0;
        end else begin
            state   <= state_nxt;
            held_pc <= held_pc_nxt;
            if (stall_if && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign hz.stall_if    = stall_if;
    assign hz.stall_id    = stall_id;
    assign hz.stall_ex    = stall_ex;
    assign hz.stall_mem   = stall_mem;
    assign hz.kill_if     = kill_if;
    assign hz.bubble_ex   = bubble_ex;
    assign hz.bubble_wb   = bubble_wb;
    assign hz.pc_redirect = pc_redirect;
    assign hz.redir_pc    = redir_pc;
    assign hz.fetch_drop  = fetch_drop;
    assign hz.stall_cnt   = stall_cnt;
    assign hz.state_dbg   = (state == HOLD);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a rule-level reference
// model; CNT_W=4 so counter saturation is reached quickly.
module tb_pipe_hazard_ctrl;
    localparam int ADDR_W = 64;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // clock/reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_hazard_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) hz ();
    pipe_hazard_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .hz(hz));

    int vectors = 0;
    int miscompares = 0;

    // reference model state: a parked redirect (pending/pend_pc) and the stall count
    bit              m_pending = 1'b0;
    logic [63:0]     m_pend_pc = '0;
    int              m_cnt = 0;
    bit              n_pending;
    logic [63:0]     n_pend_pc;
    int              n_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic idle_inputs();
        reset = 1'b0;
        hz.ireq_valid = 0; hz.ireq_data_ok = 0; hz.dreq_valid = 0; hz.dreq_data_ok = 0;
        hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.ex_valid = 0; hz.ex_memread = 0; hz.ex_rd = 0; hz.ex_flush = 0; hz.ex_target = '0;
    endtask

    task automatic random_inputs();
        reset           = ($urandom_range(0, 59) == 0);
        hz.ireq_valid   = ($urandom_range(0, 3) != 0);
        hz.ireq_data_ok = ($urandom_range(0, 2) == 0);
        hz.dreq_valid   = ($urandom_range(0, 3) == 0);
        hz.dreq_data_ok = 1'($urandom_range(0, 1));
        hz.id_rs1       = 5'($urandom_range(0, 3));
        hz.id_rs2       = 5'($urandom_range(0, 3));
        hz.id_use_rs1   = 1'($urandom_range(0, 1));
        hz.id_use_rs2   = 1'($urandom_range(0, 1));
        hz.ex_valid     = ($urandom_range(0, 3) != 0);
        hz.ex_memread   = 1'($urandom_range(0, 1));
        hz.ex_rd        = 5'($urandom_range(0, 3));
        hz.ex_flush     = ($urandom_range(0, 4) == 0);
        hz.ex_target    = {$urandom, $urandom};
    endtask

    // Called at posedge+1 with inputs driven: compare settled outputs with the model.
    task automatic settle();
        bit dwait, iwait, hazard_ld;
        bit e_sif, e_sid, e_sex, e_smem, e_kif, e_bex, e_bwb, e_pcr, e_fd;
        logic [63:0] e_redir;
        #4;
        {e_sif, e_sid, e_sex, e_smem, e_kif, e_bex, e_bwb, e_pcr, e_fd} = '0;
        e_redir   = '0;
        n_pending = m_pending;
        n_pend_pc = m_pend_pc;
        dwait     = hz.dreq_valid && !hz.dreq_data_ok;
        iwait     = hz.ireq_valid && !hz.ireq_data_ok;
        hazard_ld = hz.ex_valid && hz.ex_memread && hz.ex_rd != 0 &&
                    ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
        if (reset) begin
            n_pending = 0;
            n_pend_pc = '0;
        end else if (m_pending) begin
            e_sif = 1; e_kif = 1; e_redir = m_pend_pc;
            if (dwait) begin e_sid = 1; e_sex = 1; e_smem = 1; e_bwb = 1; end
            if (hz.ex_flush) n_pend_pc = hz.ex_target;
            if (hz.ireq_data_ok) begin e_fd = 1; e_pcr = 1; n_pending = 0; end
        end else begin
            e_redir = hz.ex_target;
            if (dwait) begin
                e_sif = 1; e_sid = 1; e_sex = 1; e_smem = 1; e_bwb = 1;
            end else if (hz.ex_flush) begin
                e_kif = 1; e_bex = 1;
                if (iwait) begin
                    n_pending = 1; n_pend_pc = hz.ex_target;
                end else begin
                    e_pcr = 1; e_fd = hz.ireq_data_ok;
                end
            end else if (hazard_ld) begin
                e_sif = 1; e_sid = 1; e_bex = 1;
            end else if (iwait) begin
                e_sif = 1; e_kif = 1;
            end
        end
        n_cnt = reset ? 0 : ((e_sif && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt);

        check("stall_if",    64'(hz.stall_if),    64'(e_sif));
        check("stall_id",    64'(hz.stall_id),    64'(e_sid));
        check("stall_ex",    64'(hz.stall_ex),    64'(e_sex));
        check("stall_mem",   64'(hz.stall_mem),   64'(e_smem));
        check("kill_if",     64'(hz.kill_if),     64'(e_kif));
        check("bubble_ex",   64'(hz.bubble_ex),   64'(e_bex));
        check("bubble_wb",   64'(hz.bubble_wb),   64'(e_bwb));
        check("pc_redirect", 64'(hz.pc_redirect), 64'(e_pcr));
        check("fetch_drop",  64'(hz.fetch_drop),  64'(e_fd));
        check("redir_pc",    hz.redir_pc,         e_redir);
        check("stall_cnt",   64'(hz.stall_cnt),   64'(m_cnt));
        check("state_dbg",   64'(hz.state_dbg),   64'(m_pending));
    endtask

    task automatic advance();
        m_pending = n_pending;
        m_pend_pc = n_pend_pc;
        m_cnt     = n_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        check("cnt_after_reset", 64'(hz.stall_cnt), 64'd0);
        idle_inputs();

        // load-use on rs1, then the same with ex_rd = x0
        hz.ex_valid = 1; hz.ex_memread = 1; hz.ex_rd = 5; hz.id_rs1 = 5; hz.id_use_rs1 = 1;
        cycle();
        hz.ex_rd = 0; hz.id_rs1 = 0;
        cycle();
        idle_inputs();

        // dbus wait for 3 cycles with a pending flush, then the flush applies
        hz.dreq_valid = 1; hz.ex_flush = 1; hz.ex_target = 64'h0000_0000_1234_5678;
        repeat (3) cycle();
        hz.dreq_data_ok = 1;
        settle();
        check("t2_redirect", 64'(hz.pc_redirect), 64'd1);
        check("t2_redir_pc", hz.redir_pc, 64'h0000_0000_1234_5678);
        advance();
        idle_inputs();

        // flush behind an in-flight ibus fetch parks in HOLD until data_ok
        hz.ireq_valid = 1; hz.ex_flush = 1; hz.ex_target = 64'h0000_0000_8000_0100;
        cycle();
        hz.ex_flush = 0; hz.ex_target = 64'hdead_beef_0000_0000;
        cycle();
        hz.ireq_data_ok = 1;
        settle();
        check("t3_fetch_drop", 64'(hz.fetch_drop), 64'd1);
        check("t3_redir_pc",   hz.redir_pc, 64'h0000_0000_8000_0100);
        advance();
        idle_inputs();

        // flush with ibus data returning the same cycle: no HOLD
        hz.ireq_valid = 1; hz.ireq_data_ok = 1; hz.ex_flush = 1; hz.ex_target = 64'h40;
        cycle();
        check("t4_no_hold", 64'(hz.state_dbg), 64'd0);
        idle_inputs();

        // stall counter saturation, then reset clears it
        hz.ireq_valid = 1;
        repeat (20) cycle();
        check("t5_cnt_sat", 64'(hz.stall_cnt), 64'(CNT_MAX));
        reset = 1;
        cycle();
        check("t5_cnt_reset", 64'(hz.stall_cnt), 64'd0);
        idle_inputs();

        // reset while in HOLD abandons the pending redirect
        hz.ireq_valid = 1; hz.ex_flush = 1; hz.ex_target = 64'h99;
        cycle();
        hz.ex_flush = 0; reset = 1;
        cycle();
        reset = 0; hz.ireq_data_ok = 1;
        settle();
        check("t6_no_drop", 64'(hz.fetch_drop), 64'd0);
        advance();
        idle_inputs();

        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
